wps_line_reader: RTL and testbench

Read-side consumer of the 24-bit pixel line FIFO in the `tx_clk` domain. It arms on a `start` pulse and pulls exactly one frame of `LINE_WORDS × FRAME_LINES` words from the FIFO. Reads are credit-limited, so the small internal output buffer can never overflow. Words are re-emitted on a valid/ready stream tagged with start-of-line, end-of-line and end-of-frame markers for the WPS sender, and a one-cycle `send_done_out` pulse clears the FIFO-side line/word counters at frame end.

---
 rtl/wps_line_reader_if.sv | 25 ++
 rtl/wps_line_reader.sv | 138 +++++++++++++
 tb/tb_wps_line_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wps_line_reader_if.sv
// FIFO read port and pixel output stream of the WPS line reader, bundled for port hookup.
// Stream handshake: a word moves when out_valid && out_ready; while out_valid is high and
// out_ready low, out_data and the sol/eol/eof markers hold steady and out_valid stays high.
interface wps_line_reader_if;
  logic        fifo_ready_in;
  logic        fifo_read_out;
  logic [23:0] fifo_data_in;
  logic        fifo_valid_in;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sol;
  logic        out_eol;
  logic        out_eof;

  modport master (
    input  fifo_ready_in, fifo_data_in, fifo_valid_in, out_ready,
    output fifo_read_out, out_data, out_valid, out_sol, out_eol, out_eof
  );

  modport slave (
    output fifo_ready_in, fifo_data_in, fifo_valid_in, out_ready,
    input  fifo_read_out, out_data, out_valid, out_sol, out_eol, out_eof
  );
endinterface

// File: rtl/wps_line_reader.sv
// Pulls one frame of pixel words from the line FIFO under a credit limit and re-emits them
// on a valid/ready stream with start-of-line, end-of-line and end-of-frame markers.
module wps_line_reader #(
  parameter int LINE_WORDS  = 80,
  parameter int FRAME_LINES = 1080,
  parameter int BUF_DEPTH   = 4
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic                 start,
  wps_line_reader_if.master    bus,
  output logic                 send_done_out,
  output logic                 busy,
  output logic [15:0]          line_cnt,
  output logic                 overflow_err,
  output logic [1:0]           fsm_state
);
  localparam int TOTAL = LINE_WORDS * FRAME_LINES;
  localparam int REQ_W = $clog2(TOTAL + 1);
  localparam int COL_W = $clog2(LINE_WORDS);
  localparam int ROW_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [REQ_W-1:0] TOTAL_L    = REQ_W'(TOTAL);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_WORDS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(FRAME_LINES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(BUF_DEPTH);
  localparam logic [OCC_W:0]   CREDIT_MAX = (OCC_W + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t           state;
  logic [REQ_W-1:0] req_cnt;
  logic [1:0]       inflight;
  logic [OCC_W-1:0] occupancy;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [23:0]      mem [BUF_DEPTH];
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic           full;
  logic           has_data;
  logic [OCC_W:0] credit;
  logic           rd_issue;
  logic           buf_wr;
  logic           pop;
  logic           inf_dec;
  logic           at_eol;
  logic           at_eof;

  // Words already requested but not yet landed still consume a buffer slot.
  assign credit   = {1'b0, occupancy} + {{(OCC_W - 1){1'b0}}, inflight};
  assign full     = (occupancy == OCC_FULL);
  assign has_data = (occupancy != '0);
  assign rd_issue = (state == READ) && bus.fifo_ready_in && (credit < CREDIT_MAX)
                    && (req_cnt < TOTAL_L);
  assign buf_wr   = bus.fifo_valid_in && !full;
  assign pop      = has_data && bus.out_ready;
  assign inf_dec  = bus.fifo_valid_in && (inflight != 2'd0);
  assign at_eol   = (col == COL_LAST);
  assign at_eof   = at_eol && (row == ROW_LAST);

  assign bus.fifo_read_out = rd_issue;
  assign bus.out_valid     = has_data;
  assign bus.out_data      = has_data ? mem[rd_ptr] : '0;
  assign bus.out_sol       = has_data && (col == '0);
  assign bus.out_eol       = has_data && at_eol;
  assign bus.out_eof       = has_data && at_eof;
  assign send_done_out     = (state == DONE);
  assign busy              = (state != IDLE);
  assign fsm_state         = 2'(state);

  always_ff @(posedge tx_clk) begin
    if (buf_wr) mem[wr_ptr] <= bus.fifo_data_in;
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state        <= IDLE;
      req_cnt      <= '0;
      inflight     <= '0;
      occupancy    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      col          <= '0;
      row          <= '0;
      line_cnt     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (buf_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);

      case ({buf_wr, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase

      case ({rd_issue, inf_dec})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase

      // A word landing in IDLE was never requested; a word landing on a full buffer is lost.
      if (bus.fifo_valid_in && (full || state == IDLE)) overflow_err <= 1'b1;

      if (pop) begin
        if (at_eol) begin
          col      <= '0;
          row      <= at_eof ? '0 : row + ROW_W'(1);
          line_cnt <= line_cnt + 16'd1;
        end else begin
          col <= col + COL_W'(1);
        end
      end

      case (state)
        IDLE: if (start) begin
          state    <= READ;
          req_cnt  <= '0;
          col      <= '0;
          row      <= '0;
          line_cnt <= '0;
        end
        READ: if (rd_issue) begin
          req_cnt <= req_cnt + REQ_W'(1);
          if (req_cnt == TOTAL_L - REQ_W'(1)) state <= DRAIN;
        end
        DRAIN: if (pop && at_eof && inflight == 2'd0) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wps_line_reader.sv
// Bench for wps_line_reader: a queue-backed FIFO with two-cycle read latency feeds the reader,
// and every transferred word is scored against its frame position.
module tb_wps_line_reader;
  localparam int LW    = 4;
  localparam int FL    = 2;
  localparam int BD    = 4;
  localparam int TOTAL = LW * FL;

  logic        tx_clk;
  logic        tx_rst;
  logic        start;
  logic        send_done_out;
  logic        busy;
  logic [15:0] line_cnt;
  logic        overflow_err;
  logic [1:0]  fsm_state;

  wps_line_reader_if bus ();

  wps_line_reader #(.LINE_WORDS(LW), .FRAME_LINES(FL), .BUF_DEPTH(BD)) dut (
    .tx_clk        (tx_clk),
    .tx_rst        (tx_rst),
    .start         (start),
    .bus           (bus),
    .send_done_out (send_done_out),
    .busy          (busy),
    .line_cnt      (line_cnt),
    .overflow_err  (overflow_err),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt, done_cnt, done_cyc, xfer_idx;
  int first_rd_cyc, last_rd_cyc, first_xfer_cyc, last_xfer_cyc;
  bit starve, rand_mode, gate_phase;
  logic        p1_v;
  logic [23:0] p1_d;
  logic [23:0] fifo_q[$];
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: each word's markers follow from its index within the frame
  task automatic score();
    logic [23:0] e;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_xfer: observed %0h expected none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_data", 32'(bus.out_data), 32'(e));
        chk("xfer_sol", 32'(bus.out_sol), 32'(xfer_idx % LW == 0));
        chk("xfer_eol", 32'(bus.out_eol), 32'(xfer_idx % LW == LW - 1));
        chk("xfer_eof", 32'(bus.out_eof), 32'(xfer_idx == TOTAL - 1));
      end
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      xfer_idx++;
    end else if (bus.out_valid && exp_q.size() != 0) begin
      chk("hold_data", 32'(bus.out_data), 32'(exp_q[0]));
    end
  endtask

  // driver: sample at negedge, update FIFO model and inputs just after posedge
  task automatic cycle();
    logic rd;
    bit   gate;
    @(negedge tx_clk);
    rd = bus.fifo_read_out;
    if (rd) begin
      chk("read_when_ready", 32'(bus.fifo_ready_in), 32'd1);
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
    end
    score();
    if (send_done_out) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge tx_clk);
    #1;
    cyc++;
    start = 1'b0;
    bus.fifo_valid_in = p1_v;
    bus.fifo_data_in  = p1_v ? p1_d : 24'h0;
    if (rd && fifo_q.size() != 0) begin
      p1_v = 1'b1;
      p1_d = fifo_q.pop_front();
    end else begin
      p1_v = 1'b0;
    end
    if (rand_mode) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      gate = 1'($urandom_range(0, 1));
    end else if (starve) begin
      gate_phase = !gate_phase;
      gate = gate_phase;
    end else begin
      gate = 1'b1;
    end
    bus.fifo_ready_in = (fifo_q.size() != 0) && gate;
  endtask

  task automatic load_frame();
    logic [23:0] w;
    for (int i = 0; i < TOTAL; i++) begin
      w = 24'($urandom_range(1, 24'hFFFFFF));
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; xfer_idx = 0;
    first_rd_cyc = -1; last_rd_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    bus.fifo_ready_in = 1'b1;
  endtask

  // mode: 0 streaming, 1 backpressure, 2 starved FIFO, 3 start while busy, 4 random
  task automatic run_frame(input int mode);
    int s_cyc;
    int budget;
    load_frame();
    starve = (mode == 2);
    rand_mode = (mode == 4);
    gate_phase = 1'b1;
    bus.out_ready = (mode == 1) ? 1'b0 : 1'b1;
    start = 1'b1;
    s_cyc = cyc;
    cycle();
    chk("busy_after_start", 32'(busy), 32'd1);
    if (mode == 3) begin
      cycle();
      cycle();
      start = 1'b1;
      cycle();
    end
    if (mode == 1) begin
      repeat (9) cycle();
      chk("bp_reads", 32'(rd_cnt), 32'(BD));
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
    end
    budget = 0;
    while (done_cnt == 0 && budget < 300) begin
      cycle();
      budget++;
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
    chk("done_timing", 32'(done_cyc - last_xfer_cyc), 32'd1);
    chk("busy_cleared", 32'(busy), 32'd0);
    chk("reads_total", 32'(rd_cnt), 32'(TOTAL));
    chk("xfers_total", 32'(xfer_idx), 32'(TOTAL));
    chk("line_cnt", 32'(line_cnt), 32'(FL));
    chk("no_overflow", 32'(overflow_err), 32'd0);
    chk("exp_empty", 32'(exp_q.size()), 32'd0);
    if (mode == 0) begin
      chk("first_read_lat", 32'(first_rd_cyc - s_cyc), 32'd1);
      chk("read_burst", 32'(last_rd_cyc - first_rd_cyc), 32'(TOTAL - 1));
      chk("first_out_lat", 32'(first_xfer_cyc - first_rd_cyc), 32'd3);
      chk("xfer_burst", 32'(last_xfer_cyc - first_xfer_cyc), 32'(TOTAL - 1));
    end
    repeat (8) cycle();
    chk("single_done", 32'(done_cnt), 32'd1);
    starve = 1'b0;
    rand_mode = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_read"}, 32'(bus.fifo_read_out), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_markers"}, 32'({bus.out_sol, bus.out_eol, bus.out_eof}), 32'd0);
    chk({tag, "_done"}, 32'(send_done_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow_err), 32'd0);
  endtask

  task automatic clear_env();
    fifo_q.delete();
    exp_q.delete();
    p1_v = 1'b0;
    bus.fifo_valid_in = 1'b0;
    bus.fifo_data_in = 24'h0;
    bus.fifo_ready_in = 1'b0;
  endtask

  initial begin
    logic [23:0] spur_q[$];
    int budget;
    tx_rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b1;
    starve = 1'b0;
    rand_mode = 1'b0;
    clear_env();
    repeat (2) @(posedge tx_clk);
    #1;
    reset_values("por");
    tx_rst = 1'b0;

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(4);
    run_frame(4);

    // reset in the middle of a frame
    load_frame();
    start = 1'b1;
    cycle();
    budget = 0;
    while (xfer_idx < 3 && budget < 100) begin
      cycle();
      budget++;
    end
    chk("mid_xfers", 32'(xfer_idx), 32'd3);
    tx_rst = 1'b1;
    #1;
    reset_values("mid_rst");
    clear_env();
    cycle();
    cycle();
    tx_rst = 1'b0;
    cycle();
    run_frame(0);

    // unrequested words in IDLE fill the buffer; the fifth is dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < BD + 1; i++) begin
      p1_v = 1'b1;
      p1_d = 24'($urandom_range(1, 24'hFFFFFF));
      spur_q.push_back(p1_d);
      cycle();
    end
    cycle();
    chk("spur_overflow", 32'(overflow_err), 32'd1);
    chk("spur_valid", 32'(bus.out_valid), 32'd1);
    chk("spur_head", 32'(bus.out_data), 32'(spur_q[0]));
    repeat (5) cycle();
    chk("spur_sticky", 32'(overflow_err), 32'd1);
    tx_rst = 1'b1;
    #1;
    chk("spur_rst_overflow", 32'(overflow_err), 32'd0);
    chk("spur_rst_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    tx_rst = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
